dmem_hs_ctrl: RTL

//  Parametrised synchronous data memory for the LSU/MEM stage. Replaces the combinational byte array.
//  - Single-outstanding valid/ready request channel and valid/ready response channel.
//  - Word-organised storage with byte-lane write masks.
//  - Load sign/zero extension.
//  - Configurable response latency.
//  - Misalignment/illegal-funct3 reported as an error response, not a simulation message.

---
 rtl/dmem_hs_if.sv | 40 ++++
 rtl/dmem_hs_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_hs_if.sv
// dmem_hs_if: request/response handshake bundle for the LSU data memory.
// master = load/store unit, slave = dmem_hs_ctrl.
interface dmem_hs_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [2:0]  req_funct3_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    modport master (
        output req_valid_i,
        output req_we_i,
        output req_addr_i,
        output req_wdata_i,
        output req_funct3_i,
        output rsp_ready_i,
        input  req_ready_o,
        input  rsp_valid_o,
        input  rsp_rdata_o,
        input  rsp_err_o
    );

    modport slave (
        input  req_valid_i,
        input  req_we_i,
        input  req_addr_i,
        input  req_wdata_i,
        input  req_funct3_i,
        input  rsp_ready_i,
        output req_ready_o,
        output rsp_valid_o,
        output rsp_rdata_o,
        output rsp_err_o
    );
endinterface

// File: rtl/dmem_hs_ctrl.sv
// dmem_hs_ctrl: single-outstanding data memory with byte-lane stores,
// load extension and fixed response latency. Define DMEM_BOUNDS_CHECK_EN to fault out-of-range offsets.
module dmem_hs_ctrl #(
    parameter int          MEM_BYTES = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          LATENCY   = 1
) (
    input logic       clk,
    input logic       rst,
    dmem_hs_if.slave  bus
);

    localparam int AW    = $clog2(MEM_BYTES);
    localparam int WORDS = MEM_BYTES / 4;
    localparam logic [1:0] LAST = 2'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state;
    logic [1:0]  cnt;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic [31:0] mem [WORDS];

    logic [31:0] offset;
    logic [AW-3:0] widx;
    logic [1:0]  lane;
    logic        accept;
    logic        f3_bad;
    logic        mis;
    logic        oob;
    logic        fault;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] word;
    logic [7:0]  bsel;
    logic [15:0] hsel;
    logic [31:0] ld;
    logic        unused_hi;

    assign offset = bus.req_addr_i - BASE_ADDR;
    assign widx   = offset[AW-1:2];
    assign lane   = offset[1:0];
    assign accept = bus.req_valid_i && req_ready;

    assign unused_hi = ^offset[31:AW];

`ifdef DMEM_BOUNDS_CHECK_EN
    assign oob = (offset >= 32'(MEM_BYTES));
`else
    assign oob = 1'b0;
`endif

    // Classify funct3 legality and alignment for the presented request
    always_comb begin
        f3_bad = 1'b0;
        mis    = 1'b0;
        case (bus.req_funct3_i)
            3'b000: mis = 1'b0;
            3'b001: mis = lane[0];
            3'b010: mis = |lane;
            3'b100: f3_bad = bus.req_we_i;
            3'b101: begin
                f3_bad = bus.req_we_i;
                mis    = lane[0];
            end
            default: f3_bad = 1'b1;
        endcase
    end

    assign fault = f3_bad | mis | oob;

    // Replicate store data across lanes and pick the lanes to enable
    always_comb begin
        be = 4'b1111;
        wd = bus.req_wdata_i;
        case (bus.req_funct3_i[1:0])
            2'b00: begin
                be = 4'b0001 << lane;
                wd = {4{bus.req_wdata_i[7:0]}};
            end
            2'b01: begin
                be = lane[1] ? 4'b1100 : 4'b0011;
                wd = {2{bus.req_wdata_i[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = bus.req_wdata_i;
            end
        endcase
    end

    // Select and extend the addressed lane of the current word
    always_comb begin
        word = mem[widx];
        bsel = word[{lane, 3'b000} +: 8];
        hsel = lane[1] ? word[31:16] : word[15:0];
        ld   = 32'h0;
        case (bus.req_funct3_i)
            3'b000:  ld = {{24{bsel[7]}}, bsel};
            3'b001:  ld = {{16{hsel[15]}}, hsel};
            3'b010:  ld = word;
            3'b100:  ld = {24'h0, bsel};
            3'b101:  ld = {16'h0, hsel};
            default: ld = 32'h0;
        endcase
    end

    // Byte-lane store on the accept edge; contents survive reset
    always_ff @(posedge clk) begin
        if (accept && bus.req_we_i && !fault) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[widx][b*8 +: 8] <= wd[b*8 +: 8];
                end
            end
        end
    end

    // Request/latency/response sequencing with registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 2'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        rsp_err   <= fault;
                        rsp_rdata <= (bus.req_we_i || fault) ? 32'h0 : ld;
                        if (LATENCY > 1) begin
                            state <= S_WAIT;
                            cnt   <= 2'd1;
                        end else begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == LAST) begin
                        state     <= S_RESP;
                        cnt       <= 2'd0;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready_i) begin
                        state     <= S_IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 32'h0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    cnt       <= 2'd0;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready_o = req_ready;
    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_rdata_o = rsp_rdata;
    assign bus.rsp_err_o   = rsp_err;

endmodule
